// File: rtl/buflet_arb.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : buflet_arb
// Description : Shares the buflet bitmap free/alloc port pair between N
//               clients. Frees first, with a burst limit protecting allocs.
//               Enforces per-client quotas and tags frees with the client id.
// Revision    : 1.0 - initial release
// ============================================================================
module buflet_arb #(
    parameter int N          = 4,
    parameter int MAX_HELD   = 8192,
    parameter int FREE_BURST = 4
) (
    input  logic              clk,
    input  logic              reset_l,
    input  logic [N-1:0]      c_free_req,
    input  logic [15*N-1:0]   c_free_page,
    output logic [N-1:0]      c_free_gnt,
    input  logic [N-1:0]      c_alloc_req,
    output logic [N-1:0]      c_alloc_gnt,
    output logic [14:0]       c_alloc_page,
    output logic [N-1:0]      c_at_quota,
    output logic              map_free_req,
    output logic [14:0]       map_free_page,
    output logic [3:0]        map_free_who,
    input  logic              map_free_gnt,
    output logic              map_alloc_req,
    input  logic              map_alloc_gnt,
    input  logic [14:0]       map_alloc_page,
    input  logic [15:0]       map_count,
    output logic              underflow_err,
    output logic [3:0]        underflow_who
);

    localparam int c_PW = (N > 1) ? $clog2(N) : 1;
    localparam int c_HW = $clog2(MAX_HELD + 1);
    localparam int c_BW = $clog2(FREE_BURST + 1);

    localparam logic [1:0] c_IDLE       = 2'd0;
    localparam logic [1:0] c_FREE_WAIT  = 2'd1;
    localparam logic [1:0] c_ALLOC_WAIT = 2'd2;
    localparam logic [1:0] c_GAP        = 2'd3;

    localparam logic [c_BW-1:0] c_BURST_MAX = c_BW'(FREE_BURST);
    localparam logic [c_HW-1:0] c_HELD_MAX  = c_HW'(MAX_HELD);

    logic [1:0]               r_state;
    logic [1:0]               w_state_nxt;
    logic [c_PW-1:0]          r_free_ptr;
    logic [c_PW-1:0]          r_alloc_ptr;
    logic [c_PW-1:0]          r_owner;
    logic [c_BW-1:0]          r_burst;
    logic [N-1:0][c_HW-1:0]   r_held;

    logic [N-1:0]             w_free_elig;
    logic [N-1:0]             w_alloc_elig;
    logic                     w_free_any;
    logic                     w_alloc_any;
    logic                     w_burst_ok;
    logic                     w_pick_free;
    logic                     w_pick_alloc;
    logic [c_PW:0]            w_fsum;
    logic [c_PW:0]            w_asum;
    logic [c_PW-1:0]          w_free_win;
    logic [c_PW-1:0]          w_alloc_win;
    logic [14:0]              w_free_page;

    function automatic logic [c_PW-1:0] f_next_ptr(input logic [c_PW-1:0] win);
        return (win == c_PW'(N - 1)) ? '0 : win + 1'b1;
    endfunction

    // An empty map makes every alloc ineligible.
    assign w_free_elig  = c_free_req;
    assign w_alloc_elig = (map_count != 16'd0) ? (c_alloc_req & ~c_at_quota) : '0;
    assign w_free_any   = |w_free_elig;
    assign w_alloc_any  = |w_alloc_elig;
    assign w_burst_ok   = (r_burst < c_BURST_MAX);
    assign w_pick_free  = (r_state == c_IDLE) && w_free_any && (!w_alloc_any || w_burst_ok);
    assign w_pick_alloc = (r_state == c_IDLE) && !w_pick_free && w_alloc_any;

    // Scan downward so the candidate nearest the pointer is the last to land.
    always_comb begin
        w_free_win  = r_free_ptr;
        w_alloc_win = r_alloc_ptr;
        w_fsum      = '0;
        w_asum      = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_fsum = {1'b0, r_free_ptr} + (c_PW + 1)'(k);
            if (w_fsum >= (c_PW + 1)'(N)) w_fsum = w_fsum - (c_PW + 1)'(N);
            if (w_free_elig[w_fsum[c_PW-1:0]]) w_free_win = w_fsum[c_PW-1:0];
            w_asum = {1'b0, r_alloc_ptr} + (c_PW + 1)'(k);
            if (w_asum >= (c_PW + 1)'(N)) w_asum = w_asum - (c_PW + 1)'(N);
            if (w_alloc_elig[w_asum[c_PW-1:0]]) w_alloc_win = w_asum[c_PW-1:0];
        end
    end

    always_comb begin
        w_free_page = '0;
        for (int i = 0; i < N; i++) begin
            if (w_free_win == c_PW'(i)) w_free_page = c_free_page[15*i +: 15];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_pick_free)       w_state_nxt = c_FREE_WAIT;
                else if (w_pick_alloc) w_state_nxt = c_ALLOC_WAIT;
            end
            c_FREE_WAIT:  if (map_free_gnt)  w_state_nxt = c_GAP;
            c_ALLOC_WAIT: if (map_alloc_gnt) w_state_nxt = c_GAP;
            c_GAP:        w_state_nxt = c_IDLE;
            default:      w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) r_state <= c_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            c_free_gnt    <= '0;
            c_alloc_gnt   <= '0;
            c_alloc_page  <= '0;
            c_at_quota    <= '0;
            map_free_req  <= 1'b0;
            map_free_page <= '0;
            map_free_who  <= '0;
            map_alloc_req <= 1'b0;
            underflow_err <= 1'b0;
            underflow_who <= '0;
            r_free_ptr    <= '0;
            r_alloc_ptr   <= '0;
            r_owner       <= '0;
            r_burst       <= '0;
            r_held        <= '0;
        end else begin
            for (int i = 0; i < N; i++) c_at_quota[i] <= (r_held[i] >= c_HELD_MAX);
            case (r_state)
                c_IDLE: begin
                    if (w_pick_free) begin
                        map_free_req  <= 1'b1;
                        map_free_page <= w_free_page;
                        map_free_who  <= 4'(w_free_win);
                        r_owner       <= w_free_win;
                        r_free_ptr    <= f_next_ptr(w_free_win);
                        if (w_alloc_any && w_burst_ok) r_burst <= r_burst + 1'b1;
                    end else if (w_pick_alloc) begin
                        map_alloc_req <= 1'b1;
                        r_owner       <= w_alloc_win;
                        r_alloc_ptr   <= f_next_ptr(w_alloc_win);
                        r_burst       <= '0;
                    end
                end
                c_FREE_WAIT: begin
                    if (map_free_gnt) begin
                        map_free_req        <= 1'b0;
                        c_free_gnt[r_owner] <= 1'b1;
                        if (r_held[r_owner] != '0) begin
                            r_held[r_owner] <= r_held[r_owner] - 1'b1;
                        end else if (!underflow_err) begin
                            underflow_err <= 1'b1;
                            underflow_who <= 4'(r_owner);
                        end
                    end
                end
                c_ALLOC_WAIT: begin
                    if (map_alloc_gnt) begin
                        map_alloc_req        <= 1'b0;
                        c_alloc_gnt[r_owner] <= 1'b1;
                        c_alloc_page         <= map_alloc_page;
                        r_held[r_owner]      <= r_held[r_owner] + 1'b1;
                    end
                end
                default: begin
                    c_free_gnt   <= '0;
                    c_alloc_gnt  <= '0;
                    c_alloc_page <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_buflet_arb.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_buflet_arb
// Description : Directed self-checking bench for buflet_arb with a simple
//               bitmap responder and request-count client models.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_buflet_arb;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            reset_l;
    logic [N-1:0]    c_free_req;
    logic [15*N-1:0] c_free_page;
    logic [N-1:0]    c_free_gnt;
    logic [N-1:0]    c_alloc_req;
    logic [N-1:0]    c_alloc_gnt;
    logic [14:0]     c_alloc_page;
    logic [N-1:0]    c_at_quota;
    logic            map_free_req;
    logic [14:0]     map_free_page;
    logic [3:0]      map_free_who;
    logic            map_free_gnt;
    logic            map_alloc_req;
    logic            map_alloc_gnt;
    logic [14:0]     map_alloc_page;
    logic [15:0]     map_count;
    logic            underflow_err;
    logic [3:0]      underflow_who;

    always #5 clk = ~clk;

    buflet_arb #(.N(N), .MAX_HELD(2), .FREE_BURST(4)) dut (
        .clk(clk), .reset_l(reset_l),
        .c_free_req(c_free_req), .c_free_page(c_free_page), .c_free_gnt(c_free_gnt),
        .c_alloc_req(c_alloc_req), .c_alloc_gnt(c_alloc_gnt), .c_alloc_page(c_alloc_page),
        .c_at_quota(c_at_quota),
        .map_free_req(map_free_req), .map_free_page(map_free_page), .map_free_who(map_free_who),
        .map_free_gnt(map_free_gnt),
        .map_alloc_req(map_alloc_req), .map_alloc_gnt(map_alloc_gnt), .map_alloc_page(map_alloc_page),
        .map_count(map_count),
        .underflow_err(underflow_err), .underflow_who(underflow_who)
    );

    typedef struct {
        bit          is_alloc;
        int          cli;
        logic [14:0] page;
        logic [3:0]  who;
    } rec_t;

    rec_t        log_q[$];
    int          free_left[N];
    int          alloc_left[N];
    bit          free_ok;
    bit          alloc_ok;
    logic [14:0] alloc_page_next;
    logic [14:0] last_free_page;
    logic [3:0]  last_who;
    int          n_checks = 0;
    int          n_fail   = 0;

    // One cycle of the client and bitmap models, evaluated on the falling edge.
    task automatic step();
        rec_t r;
        @(negedge clk);
        if (map_free_req) begin
            last_free_page = map_free_page;
            last_who       = map_free_who;
        end
        for (int i = 0; i < N; i++) begin
            if (c_free_gnt[i]) begin
                r.is_alloc = 1'b0; r.cli = i; r.page = last_free_page; r.who = last_who;
                log_q.push_back(r);
                if (free_left[i] > 0) free_left[i]--;
            end
            if (c_alloc_gnt[i]) begin
                r.is_alloc = 1'b1; r.cli = i; r.page = c_alloc_page; r.who = '0;
                log_q.push_back(r);
                if (alloc_left[i] > 0) alloc_left[i]--;
                alloc_page_next = alloc_page_next + 15'd1;
            end
            c_free_req[i]  = reset_l && (free_left[i] > 0);
            c_alloc_req[i] = reset_l && (alloc_left[i] > 0);
        end
        map_free_gnt   = map_free_req && free_ok;
        map_alloc_gnt  = map_alloc_req && alloc_ok;
        map_alloc_page = alloc_page_next;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_l = 1'b0;
        c_free_req = '0; c_alloc_req = '0; c_free_page = '0;
        map_free_gnt = 1'b0; map_alloc_gnt = 1'b0; map_alloc_page = '0;
        map_count = 16'd100;
        free_ok = 1'b1; alloc_ok = 1'b1;
        alloc_page_next = '0; last_free_page = '0; last_who = '0;
        for (int i = 0; i < N; i++) begin
            free_left[i] = 0;
            alloc_left[i] = 0;
        end
        log_q.delete();
        repeat (2) @(negedge clk);
        reset_l = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (c_free_gnt !== 4'h0) begin n_fail++; $display("FAIL reset_free_gnt: got %h expected 0", c_free_gnt); end
        n_checks++;
        if (c_alloc_gnt !== 4'h0) begin n_fail++; $display("FAIL reset_alloc_gnt: got %h expected 0", c_alloc_gnt); end
        n_checks++;
        if (c_alloc_page !== 15'h0) begin n_fail++; $display("FAIL reset_alloc_page: got %h expected 0", c_alloc_page); end
        n_checks++;
        if (c_at_quota !== 4'h0) begin n_fail++; $display("FAIL reset_at_quota: got %h expected 0", c_at_quota); end
        n_checks++;
        if ({map_free_req, map_alloc_req} !== 2'b00) begin
            n_fail++; $display("FAIL reset_map_req: got %b%b expected 00", map_free_req, map_alloc_req);
        end
        n_checks++;
        if ({map_free_page, map_free_who} !== 19'h0) begin
            n_fail++; $display("FAIL reset_map_free_fields: page %h who %h expected 0", map_free_page, map_free_who);
        end
        n_checks++;
        if ({underflow_err, underflow_who} !== 5'h0) begin
            n_fail++; $display("FAIL reset_underflow: err %b who %h expected 0", underflow_err, underflow_who);
        end
    endtask

    task automatic test_single_alloc();
        do_reset();
        alloc_page_next = 15'h0C00;
        alloc_left[0] = 1;
        step();
        step();
        n_checks++;
        if (map_alloc_req !== 1'b1) begin n_fail++; $display("FAIL single_map_alloc_req: got %b expected 1", map_alloc_req); end
        run(8);
        n_checks++;
        if (log_q.size() != 1) begin n_fail++; $display("FAIL single_grant_count: got %0d expected 1", log_q.size()); end
        if (log_q.size() >= 1) begin
            n_checks++;
            if (!(log_q[0].is_alloc && log_q[0].cli == 0 && log_q[0].page === 15'h0C00)) begin
                n_fail++;
                $display("FAIL single_grant: alloc %0b cli %0d page %h expected alloc 1 cli 0 page 0c00",
                         log_q[0].is_alloc, log_q[0].cli, log_q[0].page);
            end
        end
        n_checks++;
        if (map_alloc_req !== 1'b0) begin n_fail++; $display("FAIL single_req_drop: got %b expected 0", map_alloc_req); end
    endtask

    task automatic test_rr_alloc();
        int exp_cli[5] = '{0, 1, 2, 3, 0};
        do_reset();
        alloc_page_next = 15'h0100;
        alloc_left = '{2, 1, 1, 1};
        run(40);
        n_checks++;
        if (log_q.size() != 5) begin n_fail++; $display("FAIL rr_count: got %0d expected 5", log_q.size()); end
        for (int i = 0; i < 5; i++) begin
            if (i < log_q.size()) begin
                n_checks++;
                if (!(log_q[i].is_alloc && log_q[i].cli == exp_cli[i] && log_q[i].page === 15'h0100 + 15'(i))) begin
                    n_fail++;
                    $display("FAIL rr_order[%0d]: cli %0d page %h expected cli %0d page %h",
                             i, log_q[i].cli, log_q[i].page, exp_cli[i], 15'h0100 + 15'(i));
                end
            end
        end
        n_checks++;
        if (c_at_quota !== 4'b0001) begin n_fail++; $display("FAIL rr_quota: got %b expected 0001", c_at_quota); end
    endtask

    task automatic test_free_burst();
        bit exp_alloc[6] = '{0, 0, 0, 0, 1, 0};
        int exp_cli[6]   = '{0, 1, 2, 0, 3, 1};
        bit both_seen    = 1'b0;
        do_reset();
        c_free_page = {15'h1003, 15'h1002, 15'h1001, 15'h1000};
        free_left  = '{5, 5, 5, 0};
        alloc_left = '{0, 0, 0, 1};
        alloc_page_next = 15'h0200;
        for (int c = 0; c < 80; c++) begin
            step();
            if (map_free_req && map_alloc_req) both_seen = 1'b1;
        end
        n_checks++;
        if (both_seen) begin n_fail++; $display("FAIL burst_exclusive: both map requests seen high, expected never"); end
        n_checks++;
        if (log_q.size() != 16) begin n_fail++; $display("FAIL burst_count: got %0d expected 16", log_q.size()); end
        for (int i = 0; i < 6; i++) begin
            if (i < log_q.size()) begin
                n_checks++;
                if (log_q[i].is_alloc != exp_alloc[i] || log_q[i].cli != exp_cli[i] ||
                    (!exp_alloc[i] && (log_q[i].who !== 4'(exp_cli[i]) ||
                                       log_q[i].page !== 15'h1000 + 15'(exp_cli[i])))) begin
                    n_fail++;
                    $display("FAIL burst_seq[%0d]: alloc %0b cli %0d who %0d page %h expected alloc %0b cli %0d",
                             i, log_q[i].is_alloc, log_q[i].cli, log_q[i].who, log_q[i].page,
                             exp_alloc[i], exp_cli[i]);
                end
            end
        end
    endtask

    task automatic test_quota();
        do_reset();
        alloc_page_next = 15'h0300;
        alloc_left[1] = 2;
        run(20);
        n_checks++;
        if (log_q.size() != 2) begin n_fail++; $display("FAIL quota_first_allocs: got %0d expected 2", log_q.size()); end
        n_checks++;
        if (c_at_quota !== 4'b0010) begin n_fail++; $display("FAIL quota_set: got %b expected 0010", c_at_quota); end
        alloc_left[1] = 1;
        run(20);
        n_checks++;
        if (log_q.size() != 2 || map_alloc_req !== 1'b0) begin
            n_fail++; $display("FAIL quota_masked: grants %0d map_alloc_req %b expected 2 and 0", log_q.size(), map_alloc_req);
        end
        c_free_page[29:15] = 15'h0301;
        free_left[1] = 1;
        run(30);
        n_checks++;
        if (log_q.size() != 4) begin n_fail++; $display("FAIL quota_release_count: got %0d expected 4", log_q.size()); end
        if (log_q.size() >= 4) begin
            n_checks++;
            if (log_q[2].is_alloc || log_q[2].cli != 1 || !log_q[3].is_alloc || log_q[3].cli != 1) begin
                n_fail++;
                $display("FAIL quota_release_order: rec2 alloc %0b cli %0d rec3 alloc %0b cli %0d expected free 1 then alloc 1",
                         log_q[2].is_alloc, log_q[2].cli, log_q[3].is_alloc, log_q[3].cli);
            end
        end
        n_checks++;
        if (c_at_quota !== 4'b0010) begin n_fail++; $display("FAIL quota_reset_again: got %b expected 0010", c_at_quota); end
    endtask

    task automatic test_underflow();
        do_reset();
        c_free_page[44:30] = 15'h0222;
        free_left[2] = 1;
        run(15);
        n_checks++;
        if (log_q.size() != 1) begin n_fail++; $display("FAIL uflow_forwarded: got %0d grants expected 1", log_q.size()); end
        if (log_q.size() >= 1) begin
            n_checks++;
            if (log_q[0].who !== 4'd2 || log_q[0].page !== 15'h0222) begin
                n_fail++; $display("FAIL uflow_tag: who %0d page %h expected 2 0222", log_q[0].who, log_q[0].page);
            end
        end
        n_checks++;
        if (underflow_err !== 1'b1 || underflow_who !== 4'd2) begin
            n_fail++; $display("FAIL uflow_first: err %b who %0d expected 1 2", underflow_err, underflow_who);
        end
        c_free_page[59:45] = 15'h0333;
        free_left[3] = 1;
        run(15);
        n_checks++;
        if (log_q.size() != 2) begin n_fail++; $display("FAIL uflow_second_count: got %0d expected 2", log_q.size()); end
        if (log_q.size() >= 2) begin
            n_checks++;
            if (log_q[1].who !== 4'd3) begin n_fail++; $display("FAIL uflow_second_who: got %0d expected 3", log_q[1].who); end
        end
        n_checks++;
        if (underflow_err !== 1'b1 || underflow_who !== 4'd2) begin
            n_fail++; $display("FAIL uflow_sticky: err %b who %0d expected 1 2", underflow_err, underflow_who);
        end
    endtask

    task automatic test_map_empty_and_reset();
        do_reset();
        map_count = 16'd0;
        alloc_page_next = 15'h0400;
        alloc_left[0] = 1;
        c_free_page[29:15] = 15'h0111;
        free_left[1] = 1;
        run(20);
        n_checks++;
        if (log_q.size() != 1 || map_alloc_req !== 1'b0) begin
            n_fail++; $display("FAIL empty_alloc_held: grants %0d map_alloc_req %b expected 1 and 0", log_q.size(), map_alloc_req);
        end
        if (log_q.size() >= 1) begin
            n_checks++;
            if (log_q[0].is_alloc || log_q[0].cli != 1) begin
                n_fail++; $display("FAIL empty_free_first: alloc %0b cli %0d expected free 1", log_q[0].is_alloc, log_q[0].cli);
            end
        end
        map_count = 16'd1;
        run(15);
        n_checks++;
        if (log_q.size() != 2) begin n_fail++; $display("FAIL empty_alloc_after: got %0d expected 2", log_q.size()); end
        if (log_q.size() >= 2) begin
            n_checks++;
            if (!log_q[1].is_alloc || log_q[1].cli != 0 || log_q[1].page !== 15'h0400) begin
                n_fail++; $display("FAIL empty_alloc_rec: alloc %0b cli %0d page %h expected 1 0 0400",
                                   log_q[1].is_alloc, log_q[1].cli, log_q[1].page);
            end
        end
        free_ok = 1'b0;
        c_free_page[44:30] = 15'h0444;
        free_left[2] = 1;
        run(5);
        n_checks++;
        if (map_free_req !== 1'b1 || map_free_who !== 4'd2 || map_free_page !== 15'h0444) begin
            n_fail++; $display("FAIL stall_free_wait: req %b who %0d page %h expected 1 2 0444",
                               map_free_req, map_free_who, map_free_page);
        end
        #2;
        reset_l = 1'b0;
        c_free_req = '0;
        c_alloc_req = '0;
        #1;
        n_checks++;
        if ({map_free_req, map_alloc_req, map_free_page, map_free_who, c_free_gnt, c_alloc_gnt,
             c_alloc_page, c_at_quota, underflow_err, underflow_who} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: free_req %b who %0d page %h uflow %b expected all 0",
                     map_free_req, map_free_who, map_free_page, underflow_err);
        end
        do_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_l = 1'b0;
        c_free_req = '0; c_alloc_req = '0; c_free_page = '0;
        map_free_gnt = 1'b0; map_alloc_gnt = 1'b0; map_alloc_page = '0; map_count = '0;
        test_reset();
        test_single_alloc();
        test_rr_alloc();
        test_free_burst();
        test_quota();
        test_underflow();
        test_map_empty_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
